frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/cam_pkg.sv | 21 ++
 rtl/capture_addr_gen.sv | 75 +++++++
 rtl/frame_capture_ctrl.sv | 104 ++++++++++
 tb/tb_frame_capture_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame-capture block.
// State encoding and frame-size helpers.
package cam_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WAIT_VS = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_FINISH  = 2'd3;

  localparam int FRAME_PIXELS = 640 * 480;

  function automatic int frame_pixels(
    input int h,
    input int v
  );
    return h * v;
  endfunction

endpackage

// File: rtl/capture_addr_gen.sv
// Pixel x/y tracking and frame-buffer address generation.
// CAPTURE_DECIM_EN keeps only even-x/even-y pixels.
module capture_addr_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] PIX_C =
    CW'(frame_pixels(H_ACTIVE, V_ACTIVE));
  localparam logic [ADDR_W-1:0] X_LAST =
    ADDR_W'(H_ACTIVE - 1);

  logic [ADDR_W:0] acc;

  // acc saturates at the frame size; later pixels only flag overflow
  assign full = acc == PIX_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      acc <= '0;
    end else if (clr) begin
      x   <= '0;
      y   <= '0;
      acc <= '0;
    end else if (en && !full) begin
      acc <= acc + 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

`ifdef CAPTURE_DECIM_EN
  logic [ADDR_W:0] wcnt;

  assign wr    = en & ~full & ~x[0] & ~y[0];
  assign addr  = wcnt[ADDR_W-1:0];
  assign count = wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (clr) begin
      wcnt <= '0;
    end else if (wr) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign wr    = en & ~full;
  assign addr  = acc[ADDR_W-1:0];
  assign count = acc;
`endif

endmodule

// File: rtl/frame_capture_ctrl.sv
// Single-frame camera capture controller.
// Define CAPTURE_DECIM_EN for 2x2 decimated capture.
module frame_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int CW = ADDR_W + 1;
`ifdef CAPTURE_DECIM_EN
  localparam int EXPECT = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
  localparam int EXPECT = frame_pixels(H_ACTIVE, V_ACTIVE);
`endif
  localparam logic [ADDR_W:0] EXPECT_C = CW'(EXPECT);

  state_t state;
  state_t state_nx;

  logic              vs_q;
  logic              fall;
  logic              rise;
  logic              accept;
  logic              clr;
  logic              ovf;
  logic              wr;
  logic              full;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] pix_x;
  logic [ADDR_W-1:0] pix_y;
  logic              unused_xy;

  assign fall      = vs_q & ~vsync;
  assign rise      = ~vs_q & vsync;
  assign accept    = (state == ST_CAPTURE) & href & pix_valid;
  assign clr       = (state == ST_IDLE) & start;
  assign busy      = state != ST_IDLE;
  assign done      = state == ST_FINISH;
  assign unused_xy = ^{pix_x, pix_y};

  capture_addr_gen #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .ADDR_W  (ADDR_W)
  ) u_addr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .clr  (clr),
    .wr   (wr),
    .addr (addr),
    .count(count),
    .full (full),
    .x    (pix_x),
    .y    (pix_y)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (start) state_nx = ST_WAIT_VS;
      ST_WAIT_VS: if (fall)  state_nx = ST_CAPTURE;
      ST_CAPTURE: if (rise)  state_nx = ST_FINISH;
      default:               state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vs_q      <= 1'b1;
      ovf       <= 1'b0;
      frame_err <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state <= state_nx;
      vs_q  <= vsync;
      wr_en <= wr;
      if (wr) wr_addr <= addr;
      if (clr) ovf <= 1'b0;
      else if (accept && full) ovf <= 1'b1;
      // counters are final here: last CAPTURE pixel landed on entry
      if (state == ST_FINISH)
        frame_err <= ovf | (count != EXPECT_C);
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl on a 4x2 frame.
// Table rows, corner sequences and random frames vs a pixel-list model.
module tb_frame_capture_ctrl;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int AW  = 3;
  localparam int PIX = H * V;
`ifdef CAPTURE_DECIM_EN
  localparam int EXP_W = (H / 2) * (V / 2);
`else
  localparam int EXP_W = PIX;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic          pix_valid = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
  logic          frame_err;

  int checks = 0;
  int failures = 0;
  int got[$];
  int exp_q[$];
  bit exp_err;

  typedef struct {
    int npix;
    bit rise_pix;
    int exp_wr;
    bit exp_err;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  frame_capture_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .vsync    (vsync),
    .href     (href),
    .pix_valid(pix_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .done     (done),
    .frame_err(frame_err)
  );

  always @(negedge clk)
    if (rst_n && wr_en) got.push_back(int'(wr_addr));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // k-th accepted pixel sits at x=k%H, y=k/H; only the first PIX count
  task automatic model(input int n);
    int w;
    bit keep;
    w = 0;
    exp_q.delete();
    for (int k = 0; k < n && k < PIX; k++) begin
      keep = 1'b1;
`ifdef CAPTURE_DECIM_EN
      keep = ((k % H) % 2 == 0) && ((k / H) % 2 == 0);
`endif
      if (keep) begin
        exp_q.push_back(w);
        w++;
      end
    end
    exp_err = (n > PIX) || (exp_q.size() != EXP_W);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_frame(input int n, input bit rise_pix);
    int g;
    href = 1'b0;
    pix_valid = 1'b0;
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    for (int k = 0; k < n; k++) begin
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        case ($urandom_range(0, 2))
          0:       {href, pix_valid} = 2'b00;
          1:       {href, pix_valid} = 2'b10;
          default: {href, pix_valid} = 2'b01;
        endcase
        tick();
      end
      href = 1'b1;
      pix_valid = 1'b1;
      if (rise_pix && k == n - 1) vsync = 1'b1;
      tick();
    end
    href = 1'b0;
    pix_valid = 1'b0;
    vsync = 1'b1;
  endtask

  task automatic finish_check(input string tag, input bit err_req);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, int'(seen), 1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(frame_err), int'(err_req));
    chk({tag, "_nwr"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), got[i], exp_q[i]);
    tick();
  endtask

  initial begin
    int prev_err;
    int nd;
    int n;
    bit r;

`ifdef CAPTURE_DECIM_EN
    tbl[0] = '{8, 1'b0, 2, 1'b0};
    tbl[1] = '{7, 1'b0, 2, 1'b0};
    tbl[2] = '{8, 1'b0, 2, 1'b0};
    tbl[3] = '{10, 1'b0, 2, 1'b1};
    tbl[4] = '{8, 1'b1, 2, 1'b0};
    tbl[5] = '{0, 1'b0, 0, 1'b1};
`else
    tbl[0] = '{8, 1'b0, 8, 1'b0};
    tbl[1] = '{7, 1'b0, 7, 1'b1};
    tbl[2] = '{8, 1'b0, 8, 1'b0};
    tbl[3] = '{10, 1'b0, 8, 1'b1};
    tbl[4] = '{8, 1'b1, 8, 1'b0};
    tbl[5] = '{0, 1'b0, 0, 1'b1};
`endif

    #12;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(frame_err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      prev_err = int'(frame_err);
      pulse_start();
      chk($sformatf("tbl%0d_busy", i), int'(busy), 1);
      chk($sformatf("tbl%0d_err_hold", i), int'(frame_err), prev_err);
      model(tbl[i].npix);
      got.delete();
      do_frame(tbl[i].npix, tbl[i].rise_pix);
      finish_check($sformatf("tbl%0d", i), tbl[i].exp_err);
      chk($sformatf("tbl%0d_nwr_tbl", i), got.size(), tbl[i].exp_wr);
    end

    // start while a frame is already running
    got.delete();
    vsync = 1'b0;
    tick();
    tick();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      href = 1'b1;
      pix_valid = 1'b1;
      tick();
      href = 1'b0;
      pix_valid = 1'b0;
      tick();
    end
    vsync = 1'b1;
    tick();
    chk("mid_nowr", got.size(), 0);
    chk("mid_busy", int'(busy), 1);
    model(PIX);
    do_frame(PIX, 1'b0);
    finish_check("mid", exp_err);

    // reset in mid-capture
    model(10);
    pulse_start();
    got.delete();
    do_frame(10, 1'b0);
    finish_check("pre_rst", exp_err);
    pulse_start();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      href = 1'b1;
      pix_valid = 1'b1;
      tick();
    end
    href = 1'b0;
    pix_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", int'(wr_en), 0);
    chk("arst_wr_addr", int'(wr_addr), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_err", int'(frame_err), 0);
    vsync = 1'b1;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst_no_done", nd, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    model(PIX);
    pulse_start();
    got.delete();
    do_frame(PIX, 1'b0);
    finish_check("post_rst", exp_err);

    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(5, 11);
      r = 1'(($urandom_range(0, 1)));
      model(n);
      pulse_start();
      got.delete();
      do_frame(n, r);
      finish_check($sformatf("rnd%0d", i), exp_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
